// File: rtl/fn_sweep_pkg.sv
// Shared types and constants for the fn_sweep_ctrl block.
package fn_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  localparam int          N_IN        = 4;
  localparam int          N_IDX       = 16;
  localparam logic [15:0] GOLDEN_MASK = 16'h831B;

endpackage

// File: rtl/fn_sweep_ctrl_fn4_eval.sv
// Combinational evaluator of the 4-input function f under test.
module fn4_eval
  import fn_sweep_pkg::*;
(
  input  logic [N_IN-1:0] b,
  output logic            f
);

  // Sum-of-products form of f over b[3:0].
  always_comb begin
    f = (~b[2] & ~b[1])
      | (~b[3] & ~b[1] & ~b[0])
      | (~b[3] & ~b[2] &  b[0])
      | ( b[3] &  b[2] &  b[1] & b[0]);
  end

endmodule

// File: rtl/fn_sweep_ctrl.sv
// Sweep controller: drives indices into fn4_eval, one per SETTLE cycles,
// and accumulates the minterm mask and its population count.
// Optional feature macro FN_SWEEP_CHECK_EN adds exp_mask input and err output
// comparing the finished mask against an expected mask.
module fn_sweep_ctrl
  import fn_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [3:0]  sel,
`ifdef FN_SWEEP_CHECK_EN
  input  logic [15:0] exp_mask,
  output logic        err,
`endif
  output logic        busy,
  output logic        done,
  output logic [3:0]  idx,
  output logic [15:0] mask,
  output logic [4:0]  ones
);

  // With SETTLE=1 an index is sampled in the same cycle it is driven,
  // so HOLD is never visited.
  localparam bit         SKIP_HOLD = (SETTLE == 1);
  localparam logic [1:0] HOLD_LAST = 2'((SETTLE > 1) ? (SETTLE - 2) : 0);

  sweep_state_t state;
  logic         mode_q;
  logic [1:0]   cnt;
  logic         fval;
  logic         accept;
  logic         last;

  fn4_eval u_eval (
    .b (idx),
    .f (fval)
  );

  // Start is honoured only when no evaluation is in flight.
  always_comb begin
    accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    last   = mode_q || (idx == 4'(N_IDX - 1));
  end

  // Main sequencer: state, index, accumulated mask/count and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
      cnt    <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= 4'd0;
      mask   <= 16'd0;
      ones   <= 5'd0;
`ifdef FN_SWEEP_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        state  <= SKIP_HOLD ? ST_SAMPLE : ST_HOLD;
        mode_q <= mode;
        cnt    <= 2'd0;
        busy   <= 1'b1;
        idx    <= mode ? sel : 4'd0;
        mask   <= 16'd0;
        ones   <= 5'd0;
`ifdef FN_SWEEP_CHECK_EN
        err    <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state <= ST_SAMPLE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
          ST_SAMPLE: begin
            mask[idx] <= fval;
            if (fval) begin
              ones <= ones + 5'd1;
            end
            if (last) begin
              // idx is left on the final index until the next acceptance.
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`ifdef FN_SWEEP_CHECK_EN
              // The mask bit for idx is still 0 here, so OR in the new value.
              if (mode_q) begin
                err <= (fval != exp_mask[idx]);
              end else begin
                err <= ((mask | (16'(fval) << idx)) != exp_mask);
              end
`endif
            end else begin
              state <= SKIP_HOLD ? ST_SAMPLE : ST_HOLD;
              cnt   <= 2'd0;
              if (!mode_q) begin
                idx <= idx + 4'd1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// Bench for fn_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) share the
// same stimulus; a cycle-indexed behavioural model predicts every output.
module tb_fn_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [15:0] exp_mask = 16'h831B;

  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [3:0]  idx  [2];
  logic [15:0] mask [2];
  logic [4:0]  ones [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fn_sweep_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel),
`ifdef FN_SWEEP_CHECK_EN
    .exp_mask(exp_mask), .err(err[0]),
`endif
    .busy(busy[0]), .done(done[0]), .idx(idx[0]), .mask(mask[0]), .ones(ones[0])
  );

  fn_sweep_ctrl #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel),
`ifdef FN_SWEEP_CHECK_EN
    .exp_mask(exp_mask), .err(err[1]),
`endif
    .busy(busy[1]), .done(done[1]), .idx(idx[1]), .mask(mask[1]), .ones(ones[1])
  );

`ifndef FN_SWEEP_CHECK_EN
  assign err = 2'b00;
`endif

  // ---------------- behavioural model ----------------
  // m_t = cycle number within the current operation (1 = first cycle after
  // acceptance), 0 = nothing in flight.
  int m_t    [2];
  bit m_has  [2];
  bit m_mode [2];
  int m_sel  [2];
  bit m_err  [2];

  function automatic bit fref(int i);
    bit b3, b2, b1, b0;
    b3 = ((i >> 3) & 1) != 0;
    b2 = ((i >> 2) & 1) != 0;
    b1 = ((i >> 1) & 1) != 0;
    b0 = (i & 1) != 0;
    return (!b2 && !b1) || (!b3 && !b1 && !b0) || (!b3 && !b2 && b0) ||
           (b3 && b2 && b1 && b0);
  endfunction

  function automatic int settle_of(int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int nidx(int u);
    return m_mode[u] ? 1 : 16;
  endfunction

  function automatic int mlen(int u);
    return nidx(u) * settle_of(u);
  endfunction

  function automatic int nsamp(int u);
    int k;
    if (m_t[u] == 0) return m_has[u] ? nidx(u) : 0;
    k = (m_t[u] - 1) / settle_of(u);
    return (k < nidx(u)) ? k : nidx(u);
  endfunction

  function automatic logic [15:0] mask_of(bit md, int s, int ns);
    logic [15:0] m;
    int ix;
    m = 16'd0;
    for (int j = 0; j < ns; j++) begin
      ix = md ? s : j;
      if (fref(ix)) m = m | (16'd1 << ix);
    end
    return m;
  endfunction

  function automatic int popc(logic [15:0] m);
    int c;
    c = 0;
    for (int j = 0; j < 16; j++) c += int'(m[j]);
    return c;
  endfunction

  function automatic int e_idx(int u);
    if (!m_has[u]) return 0;
    if (m_t[u] >= 1 && m_t[u] <= mlen(u))
      return m_mode[u] ? m_sel[u] : (m_t[u] - 1) / settle_of(u);
    return m_mode[u] ? m_sel[u] : 15;
  endfunction

  function automatic bit err_calc(int u);
    if (m_mode[u]) return fref(m_sel[u]) != exp_mask[m_sel[u]];
    return mask_of(1'b0, 0, 16) != exp_mask;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_t[u]   <= 0;
        m_has[u] <= 1'b0;
        m_err[u] <= 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (start && (m_t[u] == 0 || m_t[u] == mlen(u) + 1)) begin
          m_t[u]    <= 1;
          m_has[u]  <= 1'b1;
          m_mode[u] <= mode;
          m_sel[u]  <= int'(sel);
          m_err[u]  <= 1'b0;
        end else if (m_t[u] != 0) begin
          if (m_t[u] == mlen(u)) begin
            m_t[u]   <= m_t[u] + 1;
            m_err[u] <= err_calc(u);
          end else if (m_t[u] == mlen(u) + 1) begin
            m_t[u] <= 0;
          end else begin
            m_t[u] <= m_t[u] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("busy%0d", u), 32'(busy[u]),
            32'(m_t[u] >= 1 && m_t[u] <= mlen(u)));
        chk($sformatf("done%0d", u), 32'(done[u]), 32'(m_t[u] == mlen(u) + 1));
        chk($sformatf("idx%0d", u), 32'(idx[u]), 32'(e_idx(u)));
        chk($sformatf("mask%0d", u), 32'(mask[u]),
            32'(mask_of(m_mode[u], m_sel[u], nsamp(u))));
        chk($sformatf("ones%0d", u), 32'(ones[u]),
            32'(popc(mask_of(m_mode[u], m_sel[u], nsamp(u)))));
`ifdef FN_SWEEP_CHECK_EN
        chk($sformatf("err%0d", u), 32'(err[u]), 32'(m_err[u]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int u, input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done[u] === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  task automatic kick(input bit md, input logic [3:0] s, output int c0);
    mode  = md;
    sel   = s;
    start = 1'b1;
    step();
    c0    = cyc;
    start = 1'b0;
  endtask

  initial begin
    int c0, lat;

    // Model pins: golden mask and single-index values of f.
    chk("model_golden", 32'(mask_of(1'b0, 0, 16)), 32'h831B);
    chk("model_f2", 32'(fref(2)), 32'd0);
    chk("model_f15", 32'(fref(15)), 32'd1);

    #1 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_mask", 32'(mask[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);

    // Full sweep on both instances.
    kick(1'b0, 4'd0, c0);
    wait_done(0, c0, lat);
    chk("lat_full_s1", 32'(lat), 32'd16);
    chk("mask_full_s1", 32'(mask[0]), 32'h831B);
    chk("ones_full_s1", 32'(ones[0]), 32'd7);
    wait_done(1, c0, lat);
    chk("lat_full_s3", 32'(lat), 32'd48);
    chk("mask_full_s3", 32'(mask[1]), 32'h831B);
    step();

    // Single evaluations.
    kick(1'b1, 4'd2, c0);
    wait_done(0, c0, lat);
    chk("lat_single_s1", 32'(lat), 32'd1);
    chk("mask_sel2", 32'(mask[0]), 32'd0);
    chk("ones_sel2", 32'(ones[0]), 32'd0);
    wait_done(1, c0, lat);
    chk("lat_single_s3", 32'(lat), 32'd3);
    step();
    kick(1'b1, 4'd15, c0);
    wait_done(0, c0, lat);
    chk("mask_sel15", 32'(mask[0]), 32'h8000);
    chk("ones_sel15", 32'(ones[0]), 32'd1);
    repeat (4) step();

    // Start while busy is ignored; start held in DONE restarts.
    kick(1'b0, 4'd0, c0);
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(0, c0, lat);
    chk("lat_ignore", 32'(lat), 32'd16);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_mask", 32'(mask[0]), 32'd0);
    chk("restart_busy", 32'(busy[0]), 32'd1);
    repeat (60) step();

    // Asynchronous reset mid-sweep, then a clean sweep.
    kick(1'b0, 4'd0, c0);
    repeat (7) step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_idx", 32'(idx[0]), 32'd0);
    chk("midrst_mask", 32'(mask[0]), 32'd0);
    chk("midrst_ones", 32'(ones[0]), 32'd0);
    step();
    rst = 1'b0;
    kick(1'b0, 4'd0, c0);
    wait_done(0, c0, lat);
    chk("lat_after_rst", 32'(lat), 32'd16);
    chk("mask_after_rst", 32'(mask[0]), 32'h831B);
    repeat (40) step();

`ifdef FN_SWEEP_CHECK_EN
    exp_mask = 16'h831A;
    kick(1'b0, 4'd0, c0);
    wait_done(0, c0, lat);
    chk("err_bad", 32'(err[0]), 32'd1);
    exp_mask = 16'h831B;
    kick(1'b0, 4'd0, c0);
    chk("err_clr", 32'(err[0]), 32'd0);
    wait_done(0, c0, lat);
    chk("err_good", 32'(err[0]), 32'd0);
    repeat (40) step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      mode     = 1'($urandom_range(0, 1));
      sel      = 4'($urandom_range(0, 15));
      exp_mask = ($urandom_range(0, 1) == 0) ? 16'h831B : 16'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fn_sweep_ctrl.md
FN_SWEEP_CTRL -- requirements
Module: fn_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, cycles each input index is held before sampling; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 mode  input  1  0 = full sweep of indices 0..15; 1 = single evaluation of sel.
REQ-006 sel  input  4  index for single mode; captured on start acceptance.
REQ-007 busy  output  1  high while a sweep or single evaluation is in progress.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 idx  output  4  index currently driven onto the evaluator inputs.
REQ-010 mask  output  16  minterm mask; bit i = f(i) for each evaluated index.
REQ-011 ones  output  5  population count of mask.

Function
REQ-012 f(b3..b0) SHALL be (~b2&~b1)|(~b3&~b1&~b0)|(~b3&~b2&b0)|(b3&b2&b1&b0); the golden full-sweep mask SHALL be 16'h831B, with ones = 7.
REQ-013 FSM states SHALL be IDLE, HOLD, SAMPLE, DONE; IDLE->HOLD on start; HOLD->SAMPLE after SETTLE-1 hold cycles (immediately when SETTLE=1); SAMPLE->HOLD on next index; SAMPLE->DONE after the last index; DONE->IDLE, or DONE->HOLD if start is high.
REQ-014 On start acceptance: mask and ones cleared to 0; mode and sel captured; idx loaded with 0 (full) or sel (single).
REQ-015 In SAMPLE: mask[idx] <= f(idx); ones incremented when f(idx)=1; idx incremented in full mode.
REQ-016 Latency: start accepted at edge k SHALL give done=1 in cycle k+16*SETTLE+1 (full) or k+SETTLE+1 (single).
REQ-017 busy SHALL be 1 in HOLD and SAMPLE and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-018 start while busy SHALL be ignored with no effect on state, idx, mask or ones.
REQ-019 idx SHALL not wrap past 15 into a new sweep; after the last sample it SHALL hold its last value until the next acceptance.
REQ-020 mask and ones SHALL hold their final values after done until the next acceptance.
REQ-021 Single mode SHALL update only mask[sel]; all other bits stay 0.

Reset
REQ-022 rst SHALL force IDLE immediately, including mid-sweep; outputs on reset: busy=0, done=0, idx=0, mask=0, ones=0, err=0.
REQ-023 After rst deasserts, the first start SHALL behave identically to a start after power-up.

Configuration
REQ-024 Macro FN_SWEEP_CHECK_EN, when defined, SHALL add input exp_mask [15:0] and output err [0:0].
REQ-025 With FN_SWEEP_CHECK_EN defined, err SHALL be set in the DONE cycle:
- full mode: mask != exp_mask;
- single mode: mask[sel] != exp_mask[sel];
- err held until the next start acceptance, which clears it.
REQ-026 Without FN_SWEEP_CHECK_EN, neither exp_mask nor err nor any comparison logic SHALL exist.

Structure
REQ-027 Package fn_sweep_pkg SHALL hold:
- the state enum type;
- N_IN=4 and N_IDX=16;
- GOLDEN_MASK=16'h831B.
REQ-028 Sub-module fn4_eval (combinational, 4-bit in, 1-bit out) SHALL implement f and be instantiated once, driven by idx.

Verification
REQ-029 SETTLE=1, full mode, start at edge 0 -> done pulse in cycle 17; mask=16'h831B, ones=7; busy high in cycles 1..16.
REQ-030 SETTLE=3, full mode -> done in cycle 49; mask=16'h831B.
REQ-031 Single mode:
- sel=2 -> mask=0, ones=0, done in cycle 2;
- sel=15 -> mask=16'h8000, ones=1.
REQ-032 start asserted in cycle 5 of a sweep -> ignored, done still in cycle 17; start held high in the DONE cycle -> new sweep begins, mask cleared next cycle.
REQ-033 rst asserted in cycle 8 of a sweep -> immediate IDLE with all outputs 0; a later start -> full correct sweep.
REQ-034 FN_SWEEP_CHECK_EN defined:
- exp_mask=16'h831B -> err=0;
- exp_mask=16'h831A -> err=1 at done, cleared on next start.
